// File: rtl/usb_asp_spi_target_if.sv
// SPI pin bundle between the bridge-side master and the emulated target.
// master drives SCK/CSn/MOSI; slave (target) drives MISO and its output enable.
interface usb_asp_spi_target_if;
  logic spi_clk;
  logic spi_csn;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport master (
    output spi_clk, spi_csn, spi_mosi,
    input  spi_miso, spi_miso_oe
  );

  modport slave (
    input  spi_clk, spi_csn, spi_mosi,
    output spi_miso, spi_miso_oe
  );
endinterface

// File: rtl/usb_asp_spi_target.sv
// SPI target (mode 3) with WRITE/READ/READ_ID against a byte RAM.
// Ports: clk, reset, spi (pins), rx_byte/rx_valid, host_addr/host_rdata, busy.
module usb_asp_spi_target #(
  parameter int         DEPTH = 32,
  parameter logic [7:0] ID0   = 8'hEF,
  parameter logic [7:0] ID1   = 8'h40,
  parameter logic [7:0] ID2   = 8'h16
) (
  input  logic                     clk,
  input  logic                     reset,
  usb_asp_spi_target_if.slave      spi,
  output logic [7:0]               rx_byte,
  output logic                     rx_valid,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  output logic [7:0]               host_rdata,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_RD, ADDR_WR,
    RD_DATA, WR_DATA, ID, IGNORE
  } state_t;

  state_t state, state_next;

  logic [1:0] sck_sy, csn_sy, mosi_sy;
  logic       sck_q, csn_q;
  logic       sck_s, csn_s, mosi_s;
  logic       sck_rise, sck_fall;
  logic       csn_rise, csn_fall;

  logic [2:0]    bit_cnt;
  logic [6:0]    rx_sr;
  logic [7:0]    tx, tx_next;
  logic [7:0]    byte_in;
  logic          byte_done;
  logic [AW-1:0] ptr, ptr_next, rd_addr;
  logic [1:0]    id_idx, id_next;
  logic          we;
  logic          miso_q, oe_q;
  logic [7:0]    rd_data;

  logic [7:0] mem [DEPTH];

  assign sck_s  = sck_sy[1];
  assign csn_s  = csn_sy[1];
  assign mosi_s = mosi_sy[1];

  // CSn chain resets to "selected" so a frame already in
  // progress at reset release is not mistaken for a new one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sy  <= 2'b11;
      csn_sy  <= 2'b00;
      mosi_sy <= 2'b00;
      sck_q   <= 1'b1;
      csn_q   <= 1'b0;
    end else begin
      sck_sy  <= {sck_sy[0], spi.spi_clk};
      csn_sy  <= {csn_sy[0], spi.spi_csn};
      mosi_sy <= {mosi_sy[0], spi.spi_mosi};
      sck_q   <= sck_s;
      csn_q   <= csn_s;
    end
  end

  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign csn_rise = csn_s & ~csn_q;
  assign csn_fall = ~csn_s & csn_q;

  assign byte_in   = {rx_sr, mosi_s};
  assign byte_done = (state != IDLE) & ~csn_rise & ~csn_fall
                   & sck_rise & (bit_cnt == 3'd7);

  assign rd_addr = (state == ADDR_RD) ? byte_in[AW-1:0] : ptr;
  assign rd_data = mem[rd_addr];

  always_comb begin
    state_next = state;
    tx_next    = 8'hFF;
    ptr_next   = ptr;
    id_next    = id_idx;
    we         = 1'b0;
    unique case (state)
      CMD: begin
        unique case (byte_in)
          8'h02:   state_next = ADDR_WR;
          8'h03:   state_next = ADDR_RD;
          8'h9F: begin
            state_next = ID;
            tx_next    = ID0;
            id_next    = 2'd1;
          end
          default: state_next = IGNORE;
        endcase
      end
      ADDR_WR: begin
        ptr_next   = byte_in[AW-1:0];
        state_next = WR_DATA;
      end
      ADDR_RD: begin
        ptr_next   = byte_in[AW-1:0] + 1'b1;
        tx_next    = rd_data;
        state_next = RD_DATA;
      end
      WR_DATA: begin
        we       = byte_done;
        ptr_next = ptr + 1'b1;
      end
      RD_DATA: begin
        tx_next  = rd_data;
        ptr_next = ptr + 1'b1;
      end
      ID: begin
        if (id_idx == 2'd1) begin
          tx_next = ID1;
          id_next = 2'd2;
        end else if (id_idx == 2'd2) begin
          tx_next = ID2;
          id_next = 2'd3;
        end
      end
      default: ;
    endcase
  end

  // Falling edges after the first of a byte advance MISO;
  // the first bit is already on the pin from the reload.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      rx_sr    <= 7'd0;
      tx       <= 8'hFF;
      miso_q   <= 1'b1;
      oe_q     <= 1'b0;
      rx_byte  <= 8'd0;
      rx_valid <= 1'b0;
      ptr      <= '0;
      id_idx   <= 2'd0;
    end else begin
      rx_valid <= 1'b0;
      if (csn_rise) begin
        state   <= IDLE;
        bit_cnt <= 3'd0;
        miso_q  <= 1'b1;
        oe_q    <= 1'b0;
      end else if (csn_fall) begin
        state   <= CMD;
        bit_cnt <= 3'd0;
        tx      <= 8'hFF;
        miso_q  <= 1'b1;
        oe_q    <= 1'b1;
      end else if (state != IDLE) begin
        if (sck_fall && bit_cnt != 3'd0) begin
          tx     <= {tx[6:0], 1'b1};
          miso_q <= tx[6];
        end
        if (sck_rise) begin
          rx_sr   <= byte_in[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_byte  <= byte_in;
            rx_valid <= 1'b1;
            tx       <= tx_next;
            miso_q   <= tx_next[7];
            state    <= state_next;
            ptr      <= ptr_next;
            id_idx   <= id_next;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[ptr] <= byte_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) host_rdata <= 8'd0;
    else       host_rdata <= mem[host_addr];
  end

  assign spi.spi_miso    = miso_q;
  assign spi.spi_miso_oe = oe_q;
  assign busy            = (state != IDLE);
endmodule
